// File: rtl/mem_stream_pkg.sv
// Shared defaults and FSM state encoding for the RAM-to-stream read engine.
package mem_stream_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO holding {last, data} beats for the output stream.
module stream_fifo2 #(
  parameter int unsigned W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) entry1 <= wdata;
        else        entry0 <= wdata;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = rd_ptr ? entry1 : entry0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/mem_stream_reader.sv
// Burst read engine: walks a RAM read port and streams the words out with
// valid/ready, throttling reads so the 2-entry output buffer never overflows.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  state_t            state;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  deliver_cnt;
  logic              inflight;
  logic              inflight_last;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   head;
  logic              pop_c;
  logic              credit_c;
  logic              issue_c;

  // A credit exists when buffer slots exceed occupancy plus the outstanding read;
  // a pop this cycle frees its slot immediately.
  assign m_valid  = !fifo_empty;
  assign pop_c    = m_valid && m_ready;
  assign credit_c = pop_c || (!fifo_full && !((fifo_count == 2'd1) && inflight));
  assign issue_c  = (state == RUN) && (issue_cnt != '0) && credit_c;

  assign m_data = head[DATA_W-1:0];
  assign m_last = head[DATA_W] && m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_addr       <= '0;
      issue_cnt     <= '0;
      deliver_cnt   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue_c;
      if (issue_c) inflight_last <= (issue_cnt == LEN_W'(1));

      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            rd_addr     <= base_addr;
            issue_cnt   <= len;
            deliver_cnt <= len;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (issue_c) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt - LEN_W'(1);
            if (issue_cnt == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DRAIN;
        end
        default: state <= IDLE;
      endcase

      // Burst completes on the handshake of the last outstanding word.
      if (pop_c) begin
        deliver_cnt <= deliver_cnt - LEN_W'(1);
        if (deliver_cnt == LEN_W'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  stream_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop_c),
    .wdata ({inflight_last, rd_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader against a RAM model and a queue of expected beats.
module tb_mem_stream_reader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;

  mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int beats = 0;
  int done_cnt = 0;
  logic [DW-1:0] last_data = '0;
  bit ready_auto = 1'b0;
  int ready_pct = 100;

  function automatic logic [DW-1:0] word(input int a);
    return 64'hA5A5_0000_0000_0000 + 64'(a);
  endfunction

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Stream monitor: every accepted beat must match the next expected word; stalled beats must hold.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", 64'(m_last), 64'(e.last));
        end
        beats++;
        if (m_last) last_data = m_data;
      end
      if (done) done_cnt++;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  always @(posedge clk) begin
    if (ready_auto) begin
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int b, input int l, input bit accept);
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    start     = 1'b1;
    if (accept)
      for (int k = 0; k < l; k++)
        exp_q.push_back('{data: word((b + k) % 256), last: (k == l - 1)});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int base;
    int len;
    int pct;
    int exp_last_addr;
  } vec_t;

  typedef struct {
    logic          valid;
    logic          last;
    int            idx;
    logic          dn;
    logic          bsy;
  } lat_t;

  initial begin
    vec_t vec[6];
    lat_t lat[8];
    int b0;
    int d0;
    int n;

    vec[0] = '{base: 10,  len: 4,   pct: 100, exp_last_addr: 13};
    vec[1] = '{base: 254, len: 4,   pct: 100, exp_last_addr: 1};
    vec[2] = '{base: 0,   len: 256, pct: 50,  exp_last_addr: 255};
    vec[3] = '{base: 200, len: 100, pct: 70,  exp_last_addr: 43};
    vec[4] = '{base: 255, len: 1,   pct: 30,  exp_last_addr: 255};
    vec[5] = '{base: 128, len: 3,   pct: 20,  exp_last_addr: 130};

    lat[0] = '{valid: 0, last: 0, idx: 0,  dn: 0, bsy: 1};
    lat[1] = '{valid: 0, last: 0, idx: 0,  dn: 0, bsy: 1};
    lat[2] = '{valid: 1, last: 0, idx: 10, dn: 0, bsy: 1};
    lat[3] = '{valid: 1, last: 0, idx: 11, dn: 0, bsy: 1};
    lat[4] = '{valid: 1, last: 0, idx: 12, dn: 0, bsy: 1};
    lat[5] = '{valid: 1, last: 1, idx: 13, dn: 0, bsy: 1};
    lat[6] = '{valid: 0, last: 0, idx: 0,  dn: 1, bsy: 0};
    lat[7] = '{valid: 0, last: 0, idx: 0,  dn: 0, bsy: 0};

    for (int i = 0; i < 256; i++) mem[i] = word(i);

    // Reset state
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Cycle-exact first-beat latency and done timing
    m_ready = 1'b1;
    start_burst(10, 4, 1);
    chk("lat_rd_addr", 64'(rd_addr), 64'd10);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk("lat_valid", 64'(m_valid), 64'(lat[i].valid));
      chk("lat_busy", 64'(busy), 64'(lat[i].bsy));
      chk("lat_done", 64'(done), 64'(lat[i].dn));
      if (lat[i].valid) begin
        chk("lat_data", m_data, word(lat[i].idx));
        chk("lat_last", 64'(m_last), 64'(lat[i].last));
      end
    end

    // Table of bursts under random backpressure
    foreach (vec[i]) begin
      b0 = beats;
      d0 = done_cnt;
      ready_pct  = vec[i].pct;
      ready_auto = 1'b1;
      start_burst(vec[i].base, vec[i].len, 1);
      wait_done(4000);
      ready_auto = 1'b0;
      tick();
      m_ready = 1'b1;
      chk("vec_beats", 64'(beats - b0), 64'(vec[i].len));
      chk("vec_last_data", last_data, word(vec[i].exp_last_addr));
      chk("vec_dones", 64'(done_cnt - d0), 64'd1);
    end

    // Stalled consumer: buffer fills, reads stop, then full-rate release
    m_ready = 1'b0;
    b0 = beats;
    start_burst(20, 8, 1);
    repeat (4) tick();
    chk("bp_rd_addr_a", 64'(rd_addr), 64'd22);
    repeat (5) tick();
    chk("bp_rd_addr_b", 64'(rd_addr), 64'd22);
    chk("bp_valid", 64'(m_valid), 64'd1);
    chk("bp_head", m_data, word(20));
    chk("bp_no_beats", 64'(beats - b0), 64'd0);
    m_ready = 1'b1;
    b0 = beats;
    repeat (8) tick();
    chk("bp_full_rate", 64'(beats - b0), 64'd8);
    wait_done(20);

    // Reset mid-burst after three beats, then a fresh burst
    d0 = done_cnt;
    b0 = beats;
    start_burst(40, 8, 1);
    n = 0;
    while ((beats - b0) < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_three_beats", 64'(beats - b0), 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
    b0 = beats;
    start_burst(0, 2, 1);
    wait_done(20);
    chk("post_rst_beats", 64'(beats - b0), 64'd2);
    chk("post_rst_last", last_data, word(1));

    // Start while busy is ignored
    d0 = done_cnt;
    b0 = beats;
    start_burst(60, 5, 1);
    tick();
    start_burst(100, 3, 0);
    wait_done(40);
    repeat (6) tick();
    chk("busy_start_beats", 64'(beats - b0), 64'd5);
    chk("busy_start_dones", 64'(done_cnt - d0), 64'd1);

    // Zero-length start is ignored
    d0 = done_cnt;
    start_burst(7, 0, 0);
    chk("len0_busy_a", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("len0_busy_b", 64'(busy), 64'd0);
    chk("len0_valid", 64'(m_valid), 64'd0);
    chk("len0_dones", 64'(done_cnt - d0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Sequential read engine that drains a block of the 256 × 64-bit simple dual-port RAM through its read port and presents the words as a valid/ready stream.
- The block drives the RAM read address and consumes the RAM read data, which is registered with one-cycle latency.
- It tolerates arbitrary downstream backpressure without losing or duplicating words.
- It sits between the RAM read port and any streaming consumer, such as a packetiser or checksum unit.

## Interface
Parameters:
- ADDR_W, 8, RAM address width; the RAM depth is 2**ADDR_W.
- DATA_W, 64, RAM/stream data width.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a burst; sampled only when idle.
- base_addr  input  ADDR_W  first word address; sampled with start.
- len  input  ADDR_W+1  word count, 1..256; sampled with start.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the final beat is accepted.
- rd_addr  output  ADDR_W  registered; connects to the RAM read address.
- rd_data  input  DATA_W  RAM read data; reflects the rd_addr value from the previous cycle.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.
- m_last  output  1  marks the final word of the burst; qualified by m_valid.

## Operation
State machine:
- IDLE: start=1 and len≠0 loads the address counter from base_addr, loads the remaining-to-issue count from len and the remaining-to-deliver count from len, then moves to RUN. start with len=0 is ignored: busy stays 0 and no done pulse is generated.
- RUN: issue one read per cycle while a credit is available and the issue count is non-zero. Each issue increments rd_addr modulo 2**ADDR_W, so 255 wraps to 0. When the issue count reaches 0, move to DRAIN.
- DRAIN: no further reads are issued. When the deliver count reaches 0 on a handshake, move to IDLE and pulse done.

Credits:
- The output buffer is a 2-entry FIFO.
- credits = 2 − occupancy − in-flight reads (0 or 1).
- A pop in the same cycle returns its credit in that cycle. This sustains one beat per cycle while m_ready is held high.

Capture and delivery:
- A read issued in cycle t is written into the FIFO at the end of cycle t+1. rd_data is only captured when its read was issued.
- m_valid = FIFO not empty. m_data = FIFO head. A handshake is m_valid & m_ready.
- m_last = 1 when the head word is the burst's final word.
- Once m_valid is asserted, m_data and m_last hold stable until the handshake.
- start while busy=1 is ignored, and base_addr/len changes during a burst have no effect.

Memory interaction:
- A RAM write to the address being read in the same cycle returns the old contents, because the RAM is read-before-write. This is not an error.

## Timing
Reset values:
- rst=1 asynchronously forces IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, rd_addr=0.
- The FIFO and all counters are flushed.
- A reset mid-burst discards in-flight data. No done pulse is generated.

Latency:
- Start is sampled at edge E0.
- busy=1 and rd_addr=base_addr from E0.
- The RAM samples the address at E1.
- The word is captured at E2, so m_valid=1 from E2. First-beat latency is 2 cycles.
- With m_ready=1 throughout, an N-word burst delivers N consecutive beats.
- done pulses for the one cycle after the last handshake edge, and busy falls on that same edge.
- A new start is accepted no earlier than the cycle in which done is high.

## Structure
- Package mem_stream_pkg holds ADDR_W/DATA_W defaults and the state enum state_t {IDLE, RUN, DRAIN}.
- Sub-module stream_fifo2 is the 2-entry synchronous FIFO. It has push, pop, full, empty and count outputs, and holds {last, data} per entry.
- The top module contains the FSM, counters, credit logic and rd_addr register.

## Test plan
- Preload mem[i]=64'hA5A5_0000_0000_0000+i. Start with base=10, len=4, m_ready=1 → words 10..13 on 4 consecutive cycles starting 2 cycles after start; m_last on the 13 word; done one cycle later.
- base=254, len=4 → words 254, 255, 0, 1; m_last on word 1.
- len=256, base=0, with m_ready toggling in a pseudo-random pattern → all 256 words delivered in order with no duplicates or drops; data stable while stalled; in-flight reads never exceed credit.
- m_ready=0 for 10 cycles after start with len=8 → FIFO fills to 2, rd_addr stops advancing, m_valid stays 1 holding word 0; on release, remaining words stream at full rate.
- Assert rst mid-burst (after 3 of 8 beats) → m_valid, busy and done drop immediately. A fresh start with base=0, len=2 then works normally. start while busy and start with len=0 are ignored.
